sbox_lane_arbiter: RTL and testbench



---
 rtl/sbox_lane_arbiter.sv | 145 ++++++++++++++
 tb/tb_sbox_lane_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sbox_lane_arbiter.sv
// One shared 32-bit SubWord lane serving a 4-beat state job and single key words,
// with round-robin arbitration between the two requesters.
module sbox_lane_arbiter #(
  parameter bit KEY_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stReqValid,
  output logic         stReqReady,
  input  logic [127:0] stIn,
  output logic         stRespValid,
  output logic [127:0] stOut,
  input  logic         kwReqValid,
  output logic         kwReqReady,
  input  logic [31:0]  kwIn,
  output logic         kwRespValid,
  output logic [31:0]  kwOut,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         last_key_q, last_key_d;
  logic [127:0] stbuf_q, stbuf_d;
  logic [31:0]  kw_out_q, kw_out_d;
  logic         kw_vld_q, kw_vld_d;

  logic        st_cand, key_cand, grant_st, grant_key, accept;
  logic [31:0] cur_word, lane_in, lane_out;

  always_comb begin
    st_cand   = rst_n && (state_q == S_RUN);
    key_cand  = rst_n && kwReqValid;
    // On a tie the key word wins only if the state job was granted last.
    grant_key = key_cand && (!st_cand || !last_key_q);
    grant_st  = st_cand && !grant_key;
    accept    = rst_n && stReqValid && ((state_q == S_IDLE) || (state_q == S_DONE));

    case (cnt_q)
      2'd0:    cur_word = stbuf_q[127:96];
      2'd1:    cur_word = stbuf_q[95:64];
      2'd2:    cur_word = stbuf_q[63:32];
      default: cur_word = stbuf_q[31:0];
    endcase
    lane_in  = grant_key ? kwIn : cur_word;
    lane_out = sub_word(lane_in);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_key_d = last_key_q;
    stbuf_d    = stbuf_q;
    kw_out_d   = kw_out_q;
    kw_vld_d   = grant_key;

    if (grant_key || grant_st) last_key_d = grant_key;
    if (grant_key) kw_out_d = lane_out;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stbuf_d = stIn;
          cnt_d   = 2'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (grant_st) begin
          case (cnt_q)
            2'd0:    stbuf_d[127:96] = lane_out;
            2'd1:    stbuf_d[95:64]  = lane_out;
            2'd2:    stbuf_d[63:32]  = lane_out;
            default: stbuf_d[31:0]   = lane_out;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (accept) begin
          stbuf_d = stIn;
          cnt_d   = 2'd0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      last_key_q <= ~KEY_FIRST;
      stbuf_q    <= '0;
      kw_out_q   <= '0;
      kw_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_key_q <= last_key_d;
      stbuf_q    <= stbuf_d;
      kw_out_q   <= kw_out_d;
      kw_vld_q   <= kw_vld_d;
    end
  end

  assign stReqReady  = rst_n && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign kwReqReady  = grant_key;
  assign stRespValid = (state_q == S_DONE);
  assign busy        = (state_q == S_RUN);
  assign stOut       = stbuf_q;
  assign kwOut       = kw_out_q;
  assign kwRespValid = kw_vld_q;

endmodule

// File: tb/tb_sbox_lane_arbiter.sv
// Directed bench for sbox_lane_arbiter: reset, uncontended and contended state jobs,
// key words, mid-job reset and back-to-back jobs.
module tb_sbox_lane_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stReqValid;
  logic         stReqReady;
  logic [127:0] stIn;
  logic         stRespValid;
  logic [127:0] stOut;
  logic         kwReqValid;
  logic         kwReqReady;
  logic [31:0]  kwIn;
  logic         kwRespValid;
  logic [31:0]  kwOut;
  logic         busy;

  int nchk = 0;
  int nerr = 0;

  localparam logic [127:0] VEC_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP_A = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] VEC_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] EXP_B = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] EXP_Z = {16{8'h63}};

  logic [31:0] kw_vec [4];
  logic [31:0] kw_exp [4];

  sbox_lane_arbiter #(.KEY_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .stReqValid(stReqValid), .stReqReady(stReqReady), .stIn(stIn),
    .stRespValid(stRespValid), .stOut(stOut),
    .kwReqValid(kwReqValid), .kwReqReady(kwReqReady), .kwIn(kwIn),
    .kwRespValid(kwRespValid), .kwOut(kwOut), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    kw_vec[0] = 32'hcf4f3c09; kw_exp[0] = 32'h8a84eb01;
    kw_vec[1] = 32'h13131313; kw_exp[1] = 32'h7d7d7d7d;
    kw_vec[2] = 32'h00112233; kw_exp[2] = 32'h638293c3;
    kw_vec[3] = 32'hffeeddcc; kw_exp[3] = 32'h1628c14b;

    // Reset held for 3 cycles with both requesters active.
    rst_n = 1'b0; stReqValid = 1'b1; kwReqValid = 1'b1;
    stIn = VEC_A; kwIn = 32'hcf4f3c09;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_stRespValid", stRespValid, 0);
      chk("rst_kwRespValid", kwRespValid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stOut", stOut, 0);
      chk("rst_kwOut", kwOut, 0);
      chk("rst_stReqReady", stReqReady, 0);
      chk("rst_kwReqReady", kwReqReady, 0);
    end
    stReqValid = 1'b0; kwReqValid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_stReqReady", stReqReady, 1);
    chk("rel_busy", busy, 0);
    chk("rel_kwReqReady", kwReqReady, 0);

    // Uncontended state job accepted in cycle T.
    tick();
    stReqValid = 1'b1; stIn = VEC_A;
    #1;
    chk("unc_accept_ready", stReqReady, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      stReqValid = 1'b0;
      #1;
      chk("unc_busy", busy, 1);
      chk("unc_no_resp", stRespValid, 0);
      chk("unc_not_ready", stReqReady, 0);
    end
    tick();
    chk("unc_resp_T5", stRespValid, 1);
    chk("unc_stOut", stOut, EXP_A);
    chk("unc_busy_done", busy, 0);
    tick();
    chk("unc_resp_pulse", stRespValid, 0);
    chk("unc_stOut_hold", stOut, EXP_A);

    // Contended job: key words start the cycle after the accept.
    stReqValid = 1'b1; stIn = VEC_B;
    #1;
    chk("con_accept_ready", stReqReady, 1);
    tick();
    stReqValid = 1'b0;
    kwReqValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      kwIn = kw_vec[i];
      #1;
      chk("con_key_grant", kwReqReady, 1);
      tick();
      kwIn = 32'h0;
      #1;
      chk("con_kwRespValid", kwRespValid, 1);
      chk("con_kwOut", kwOut, kw_exp[i]);
      chk("con_state_grant", kwReqReady, 0);
      chk("con_no_st_resp", stRespValid, 0);
      tick();
    end
    kwReqValid = 1'b0;
    #1;
    chk("con_resp_T9", stRespValid, 1);
    chk("con_stOut", stOut, EXP_B);
    chk("con_kw_pulse", kwRespValid, 0);

    // Standalone key word.
    tick();
    chk("con_resp_pulse", stRespValid, 0);
    kwReqValid = 1'b1; kwIn = 32'h13131313;
    #1;
    chk("kw_grant", kwReqReady, 1);
    tick();
    kwReqValid = 1'b0;
    #1;
    chk("kw_resp", kwRespValid, 1);
    chk("kw_out", kwOut, 32'h7d7d7d7d);
    tick();
    chk("kw_pulse", kwRespValid, 0);
    chk("kw_out_hold", kwOut, 32'h7d7d7d7d);

    // Reset after beat 2 of a job.
    stReqValid = 1'b1; stIn = VEC_A;
    tick();
    stReqValid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy_rst", busy, 0);
    chk("mid_ready_rst", stReqReady, 0);
    chk("mid_stOut_rst", stOut, 0);
    tick();
    chk("mid_no_resp_a", stRespValid, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid_no_resp_b", stRespValid, 0);
      tick();
    end
    chk("mid_idle_busy", busy, 0);
    stReqValid = 1'b1; stIn = '0;
    #1;
    chk("mid_accept_ready", stReqReady, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      stReqValid = 1'b0;
      #1;
      chk("mid_job_no_resp", stRespValid, 0);
    end
    tick();
    chk("mid_resp_T5", stRespValid, 1);
    chk("mid_stOut", stOut, EXP_Z);

    // Back-to-back: second job accepted in the DONE cycle of the first.
    tick();
    stReqValid = 1'b1; stIn = VEC_A;
    for (int k = 1; k <= 5; k++) begin
      tick();
      stReqValid = 1'b0;
    end
    stReqValid = 1'b1; stIn = VEC_B;
    #1;
    chk("b2b_resp1", stRespValid, 1);
    chk("b2b_stOut1", stOut, EXP_A);
    chk("b2b_ready_done", stReqReady, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      stReqValid = 1'b0;
      #1;
      chk("b2b_busy", busy, 1);
      chk("b2b_no_resp", stRespValid, 0);
    end
    tick();
    chk("b2b_resp2", stRespValid, 1);
    chk("b2b_stOut2", stOut, EXP_B);
    tick();
    chk("b2b_idle", stRespValid, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
